// File: rtl/boutons_pkg.sv
// Shared types and helpers for the button poll master and its debouncers.
package boutons_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } poll_state_e;

    localparam int unsigned POLL_PERIOD_DEFAULT = 50000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/boutons_debounce.sv
// One-bit debouncer: state flips only after DEBOUNCE_COUNT consecutive
// differing samples, emitting a one-cycle press or release pulse.
module boutons_debounce
    import boutons_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en_i,
    input  logic raw_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_en_i) begin
            if (raw_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = raw_i;
                cnt_d     = '0;
                press_d   = raw_i;
                release_d = ~raw_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/boutons_poll_master.sv
// Avalon-MM read master polling the button PIO at address 0 and publishing
// debounced button state plus press/release pulses.
module boutons_poll_master
    import boutons_pkg::*;
#(
    parameter int unsigned NB_BOUTONS     = 2,
    parameter int unsigned POLL_PERIOD    = POLL_PERIOD_DEFAULT,
    parameter int unsigned DEBOUNCE_COUNT = 4,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned ACTIVE_LOW     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    output logic [NB_BOUTONS-1:0] btn_state,
    output logic [NB_BOUTONS-1:0] btn_press,
    output logic [NB_BOUTONS-1:0] btn_release,
    output logic                  busy
);

    localparam int unsigned TW = cnt_width(POLL_PERIOD);
    localparam int unsigned LW = cnt_width(READ_LATENCY);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [LW-1:0] LAT_LAST   = LW'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
    localparam logic [NB_BOUTONS-1:0] RAW_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [TW-1:0]   timer_q, timer_d;
    logic            tick;
    poll_state_e     state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            read_q, read_d;
    logic            sample_en;
    logic [NB_BOUTONS-1:0] raw;
    logic            unused_readdata;

    assign tick    = (timer_q == TIMER_LAST);
    assign timer_d = tick ? '0 : timer_q + TW'(1);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_REQ;
            end
            S_REQ: begin
                if (read_q && !avm_waitrequest) begin
                    lat_d   = '0;
                    state_d = (READ_LATENCY > 1) ? S_WAIT : S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) state_d = S_CAPTURE;
                else                   lat_d   = lat_q + LW'(1);
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign read_d = (state_d == S_REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            state_q <= S_IDLE;
            lat_q   <= '0;
            read_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            state_q <= state_d;
            lat_q   <= lat_d;
            read_q  <= read_d;
        end
    end

    assign avm_address = '0;
    assign avm_read    = read_q;
    assign busy        = (state_q != S_IDLE);

    // The debouncers register the CAPTURE-cycle readdata themselves, so the
    // capture register and the debounce evaluation share one clock edge.
    assign sample_en       = (state_q == S_CAPTURE);
    assign raw             = avm_readdata[NB_BOUTONS-1:0] ^ RAW_MASK;
    assign unused_readdata = ^avm_readdata[31:NB_BOUTONS];

    for (genvar i = 0; i < NB_BOUTONS; i++) begin : g_btn
        boutons_debounce #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_debounce (
            .clk        (clk),
            .reset_n    (reset_n),
            .sample_en_i(sample_en),
            .raw_i      (raw[i]),
            .state_o    (btn_state[i]),
            .press_o    (btn_press[i]),
            .release_o  (btn_release[i])
        );
    end

endmodule

// File: tb/tb_boutons_poll_master.sv
// Directed bench for boutons_poll_master with an 8-cycle poll period.
module tb_boutons_poll_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h3;
    logic [1:0]  btn_state, btn_press, btn_release;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boutons_poll_master #(
        .NB_BOUTONS    (2),
        .POLL_PERIOD   (8),
        .DEBOUNCE_COUNT(3),
        .READ_LATENCY  (1),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .btn_state      (btn_state),
        .btn_press      (btn_press),
        .btn_release    (btn_release),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until avm_read is seen high, bounded.
    task automatic wait_read(output int n);
        n = 0;
        while (avm_read !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("read_timeout", 32'(avm_read), 32'd1);
    endtask

    // One poll: drive readdata for its capture, check outputs the cycle after
    // capture and that pulses are gone the cycle after that.
    task automatic poll(input logic [31:0] rd, input string tag,
                        input logic [1:0] exp_st, input logic [1:0] exp_pr,
                        input logic [1:0] exp_rl);
        int n;
        wait_read(n);
        avm_readdata = rd;
        @(negedge clk);
        chk({tag, "_read_one_cycle"}, 32'(avm_read), 32'd0);
        @(negedge clk);
        chk({tag, "_state"},   32'(btn_state),   32'(exp_st));
        chk({tag, "_press"},   32'(btn_press),   32'(exp_pr));
        chk({tag, "_release"}, 32'(btn_release), 32'(exp_rl));
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'({btn_press, btn_release}), 32'd0);
    endtask

    initial begin
        int n;
        int lows;

        repeat (3) @(negedge clk);
        chk("rst_read",  32'(avm_read), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_addr",  32'(avm_address), 32'd0);
        chk("rst_outs",  32'({btn_state, btn_press, btn_release}), 32'd0);

        // Idle polling with buttons released.
        reset_n = 1'b1;
        wait_read(n);
        chk("first_read_cycle", 32'(n), 32'd8);
        chk("first_read_busy",  32'(busy), 32'd1);
        @(negedge clk);
        chk("first_read_drop", 32'(avm_read), 32'd0);
        wait_read(n);
        chk("poll_period", 32'(n), 32'd7);
        @(negedge clk);
        chk("capture_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_outs", 32'({btn_state, btn_press, btn_release}), 32'd0);
        poll(32'h3, "idle", 2'b00, 2'b00, 2'b00);

        // Bit 0 pressed and held; upper readdata bits must be ignored.
        poll(32'h2,        "hold1", 2'b00, 2'b00, 2'b00);
        poll(32'hFFFF_FFF2, "hold2", 2'b00, 2'b00, 2'b00);
        poll(32'h2,        "hold3", 2'b01, 2'b01, 2'b00);

        // Bit 0 released again.
        poll(32'h3, "rel1", 2'b01, 2'b00, 2'b00);
        poll(32'h3, "rel2", 2'b01, 2'b00, 2'b00);
        poll(32'h3, "rel3", 2'b00, 2'b00, 2'b01);

        // A matching sample mid-run restarts the count.
        poll(32'h2, "run1", 2'b00, 2'b00, 2'b00);
        poll(32'h2, "run2", 2'b00, 2'b00, 2'b00);
        poll(32'h3, "run3", 2'b00, 2'b00, 2'b00);
        poll(32'h2, "run4", 2'b00, 2'b00, 2'b00);
        poll(32'h2, "run5", 2'b00, 2'b00, 2'b00);
        poll(32'h2, "run6", 2'b01, 2'b01, 2'b00);

        // Bit 1 pressed -> both pressed.
        poll(32'h0, "both1", 2'b01, 2'b00, 2'b00);
        poll(32'h0, "both2", 2'b01, 2'b00, 2'b00);
        poll(32'h0, "both3", 2'b11, 2'b10, 2'b00);

        // readdata=1 means bit 1 pressed, bit 0 released.
        poll(32'h1, "r01_1", 2'b11, 2'b00, 2'b00);
        poll(32'h1, "r01_2", 2'b11, 2'b00, 2'b00);
        poll(32'h1, "r01_3", 2'b10, 2'b00, 2'b01);

        // Simultaneous press on bit 0 and release on bit 1.
        poll(32'h2, "swap1", 2'b10, 2'b00, 2'b00);
        poll(32'h2, "swap2", 2'b10, 2'b00, 2'b00);
        poll(32'h2, "swap3", 2'b01, 2'b01, 2'b10);

        // Slave stall of 20 cycles: read held, ticks during stall dropped.
        wait_read(n);
        avm_waitrequest = 1'b1;
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (avm_read !== 1'b1) lows++;
        end
        chk("stall_read_held", 32'(lows), 32'd0);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_capture_read", 32'(avm_read), 32'd0);
        chk("stall_capture_busy", 32'(busy), 32'd1);
        wait_read(n);
        chk("stall_next_read", 32'(n), 32'd3);

        // Asynchronous reset while a read is pending.
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_read", 32'(avm_read), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_outs", 32'({btn_state, btn_press, btn_release}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_read(n);
        chk("post_rst_first_read", 32'(n), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
